matrix_store_writer: RTL and testbench

//  Storage-manager write port: accepts one matrix from a result producer (conv, add, mul, ...)
//  via write_request/writer_ready/data_valid/write_done and streams metadata + payload into slot

---
 rtl/matrix_op_defs_pkg.sv | 24 ++
 rtl/matrix_store_writer.sv | 206 ++++++++++++++++++++
 tb/tb_matrix_store_writer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_op_defs_pkg.sv
// Shared definitions for the matrix storage manager: slot geometry, header encoding and the
// writer FSM state type.
package matrix_op_defs_pkg;

  localparam int unsigned MATRIX_BLOCK_SIZE     = 256;
  localparam int unsigned MATRIX_ADDR_WIDTH     = 11;
  localparam int unsigned MATRIX_DATA_WIDTH     = 32;
  localparam int unsigned MATRIX_METADATA_WORDS = 3;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWriteMeta,
    StWriteData,
    StDone
  } writer_state_e;

  // Header word 0; decode_shape_word on the read side takes rows from [15:8], cols from [7:0].
  function automatic logic [31:0] encode_shape_word(input logic [7:0] rows,
                                                    input logic [7:0] cols);
    return {16'd0, rows, cols};
  endfunction

endpackage

// File: rtl/matrix_store_writer.sv
// Matrix BRAM write port: accepts one matrix from a producer, writes its header and payload
// into slot matrix_id and maintains the per-slot valid bitmap.
module matrix_store_writer
  import matrix_op_defs_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = MATRIX_BLOCK_SIZE,
  parameter int unsigned ADDR_WIDTH = MATRIX_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MATRIX_DATA_WIDTH,
  parameter int unsigned META_WORDS = MATRIX_METADATA_WORDS,
  parameter int unsigned NUM_SLOTS  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_request,
  output logic                  write_ready,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            actual_rows,
  input  logic [7:0]            actual_cols,
  input  logic [0:7][7:0]       matrix_name,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  writer_ready,
  output logic                  write_done,
  output logic                  write_error,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  output logic [NUM_SLOTS-1:0]  slot_valid
);

  localparam int unsigned MetaW      = (META_WORDS > 1) ? $clog2(META_WORDS) : 1;
  localparam int unsigned PayloadMax = BLOCK_SIZE - META_WORDS;

  writer_state_e state_q, state_d;

  logic [2:0]            id_q, id_d;
  logic [7:0]            rows_q, rows_d, cols_q, cols_d;
  logic [0:7][7:0]       name_q, name_d;
  logic [15:0]           total_q, total_d;
  logic [MetaW-1:0]      meta_idx_q, meta_idx_d;
  logic [15:0]           data_idx_q, data_idx_d;
  logic                  error_q, error_d;
  logic                  write_ready_q, write_ready_d;
  logic                  writer_ready_q, writer_ready_d;
  logic                  write_done_q, write_done_d;
  logic                  write_error_q, write_error_d;
  logic                  bram_we_q, bram_we_d;
  logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
  logic [NUM_SLOTS-1:0]  slot_valid_q, slot_valid_d;

  logic [ADDR_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] meta_word;
  logic                  check_err;
  logic                  meta_last;
  logic                  data_last;

  assign base      = ADDR_WIDTH'(id_q) * ADDR_WIDTH'(BLOCK_SIZE);
  assign check_err = (rows_q == 8'd0) || (cols_q == 8'd0) || (32'(total_q) > PayloadMax);
  assign meta_last = (meta_idx_q == MetaW'(META_WORDS - 1));
  assign data_last = (data_idx_q == total_q - 16'd1);

  always_comb begin
    meta_word = '0;
    if (meta_idx_q == MetaW'(0)) begin
      meta_word = DATA_WIDTH'(encode_shape_word(rows_q, cols_q));
    end else if (meta_idx_q == MetaW'(1)) begin
      meta_word = DATA_WIDTH'({name_q[0], name_q[1], name_q[2], name_q[3]});
    end else begin
      meta_word = DATA_WIDTH'({name_q[4], name_q[5], name_q[6], name_q[7]});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (write_request) state_d = StCheck;
      StCheck:     state_d = check_err ? StDone : StWriteMeta;
      StWriteMeta: if (meta_last) state_d = StWriteData;
      StWriteData: if (data_valid && data_last) state_d = StDone;
      StDone:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    id_d           = id_q;
    rows_d         = rows_q;
    cols_d         = cols_q;
    name_d         = name_q;
    total_d        = total_q;
    meta_idx_d     = meta_idx_q;
    data_idx_d     = data_idx_q;
    error_d        = error_q;
    write_ready_d  = write_ready_q;
    writer_ready_d = writer_ready_q;
    write_done_d   = 1'b0;
    write_error_d  = 1'b0;
    bram_we_d      = 1'b0;
    bram_addr_d    = bram_addr_q;
    bram_din_d     = bram_din_q;
    slot_valid_d   = slot_valid_q;
    unique case (state_q)
      StIdle: begin
        if (write_request) begin
          id_d          = matrix_id;
          rows_d        = actual_rows;
          cols_d        = actual_cols;
          name_d        = matrix_name;
          total_d       = {8'd0, actual_rows} * {8'd0, actual_cols};
          write_ready_d = 1'b0;
        end
      end
      StCheck: begin
        error_d = check_err;
        if (!check_err) begin
          // Invalidate first so no reader sees a half-written slot.
          slot_valid_d[id_q] = 1'b0;
          meta_idx_d         = '0;
        end
      end
      StWriteMeta: begin
        bram_we_d   = 1'b1;
        bram_addr_d = base + ADDR_WIDTH'(meta_idx_q);
        bram_din_d  = meta_word;
        meta_idx_d  = meta_idx_q + MetaW'(1);
        if (meta_last) begin
          data_idx_d     = '0;
          writer_ready_d = 1'b1;
        end
      end
      StWriteData: begin
        if (data_valid) begin
          bram_we_d   = 1'b1;
          bram_addr_d = base + ADDR_WIDTH'(META_WORDS) + ADDR_WIDTH'(data_idx_q);
          bram_din_d  = data_in;
          data_idx_d  = data_idx_q + 16'd1;
          if (data_last) writer_ready_d = 1'b0;
        end
      end
      StDone: begin
        write_done_d  = 1'b1;
        write_error_d = error_q;
        write_ready_d = 1'b1;
        if (!error_q) slot_valid_d[id_q] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q           <= '0;
      rows_q         <= '0;
      cols_q         <= '0;
      name_q         <= '0;
      total_q        <= '0;
      meta_idx_q     <= '0;
      data_idx_q     <= '0;
      error_q        <= 1'b0;
      write_ready_q  <= 1'b1;
      writer_ready_q <= 1'b0;
      write_done_q   <= 1'b0;
      write_error_q  <= 1'b0;
      bram_we_q      <= 1'b0;
      bram_addr_q    <= '0;
      bram_din_q     <= '0;
      slot_valid_q   <= '0;
    end else begin
      id_q           <= id_d;
      rows_q         <= rows_d;
      cols_q         <= cols_d;
      name_q         <= name_d;
      total_q        <= total_d;
      meta_idx_q     <= meta_idx_d;
      data_idx_q     <= data_idx_d;
      error_q        <= error_d;
      write_ready_q  <= write_ready_d;
      writer_ready_q <= writer_ready_d;
      write_done_q   <= write_done_d;
      write_error_q  <= write_error_d;
      bram_we_q      <= bram_we_d;
      bram_addr_q    <= bram_addr_d;
      bram_din_q     <= bram_din_d;
      slot_valid_q   <= slot_valid_d;
    end
  end

  assign write_ready  = write_ready_q;
  assign writer_ready = writer_ready_q;
  assign write_done   = write_done_q;
  assign write_error  = write_error_q;
  assign bram_we      = bram_we_q;
  assign bram_addr    = bram_addr_q;
  assign bram_din     = bram_din_q;
  assign slot_valid   = slot_valid_q;

endmodule

// File: tb/tb_matrix_store_writer.sv
// Directed, table-driven bench for matrix_store_writer with a BRAM capture model.
module tb_matrix_store_writer;

  localparam int Block = 256;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            write_request;
  logic            write_ready;
  logic [2:0]      matrix_id;
  logic [7:0]      actual_rows;
  logic [7:0]      actual_cols;
  logic [0:7][7:0] matrix_name;
  logic [31:0]     data_in;
  logic            data_valid;
  logic            writer_ready;
  logic            write_done;
  logic            write_error;
  logic            bram_we;
  logic [10:0]     bram_addr;
  logic [31:0]     bram_din;
  logic [7:0]      slot_valid;

  matrix_store_writer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_request(write_request),
    .write_ready  (write_ready),
    .matrix_id    (matrix_id),
    .actual_rows  (actual_rows),
    .actual_cols  (actual_cols),
    .matrix_name  (matrix_name),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .writer_ready (writer_ready),
    .write_done   (write_done),
    .write_error  (write_error),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_din     (bram_din),
    .slot_valid   (slot_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  id;
    logic [7:0]  rows;
    logic [7:0]  cols;
    logic [63:0] name;
    bit          gap;
    bit          extra;
    logic [31:0] seed;
    bit          exp_err;
    logic [7:0]  exp_sv;
  } vec_t;

  vec_t vecs[8];

  int n_cmp = 0;
  int n_bad = 0;

  // BRAM capture model and event counters, sampled on the falling edge.
  logic [31:0] mem [0:2047];
  int cyc = 0;
  int wcount = 0;
  int done_cnt = 0;
  int last_we_cyc = 0;
  int done_cyc = 0;
  logic done_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_we) begin
      mem[bram_addr] <= bram_din;
      wcount         <= wcount + 1;
      last_we_cyc    <= cyc;
    end
    if (write_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      done_err <= write_error;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int guard;
    int b;
    int k;
    int total;
    int w0;
    int d0;
    int base;
    total = int'(v.rows) * int'(v.cols);
    base  = int'(v.id) * Block;
    w0    = wcount;
    d0    = done_cnt;
    guard = 0;
    while (!write_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("write_ready_before_req", {31'd0, write_ready}, 32'd1);
    write_request = 1'b1;
    matrix_id     = v.id;
    actual_rows   = v.rows;
    actual_cols   = v.cols;
    matrix_name   = v.name;
    @(negedge clk);
    guard = 0;
    while (!writer_ready && !write_done && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    write_request = 1'b0;
    if (writer_ready) begin
      b = 0;
      k = 0;
      while (b < total && k < 4000) begin
        data_valid = v.gap ? (k % 2 == 0) : 1'b1;
        data_in    = v.seed + b;
        if (data_valid) b++;
        k++;
        @(negedge clk);
      end
      chk("writer_ready_drop", {31'd0, writer_ready}, 32'd0);
      if (v.extra) begin
        data_valid = 1'b1;
        data_in    = 32'hDEADBEEF;
        @(negedge clk);
      end
      data_valid = 1'b0;
    end
    guard = 0;
    while (done_cnt == d0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("write_error", {31'd0, done_err}, {31'd0, v.exp_err});
    chk("bram_write_count", wcount - w0, v.exp_err ? 0 : 3 + total);
    chk("slot_valid", {24'd0, slot_valid}, {24'd0, v.exp_sv});
    if (!v.exp_err) begin
      chk("done_after_last_write", done_cyc - last_we_cyc, 1);
      chk("hdr_shape", mem[base], {16'd0, v.rows, v.cols});
      chk("hdr_name0", mem[base + 1], v.name[63:32]);
      chk("hdr_name1", mem[base + 2], v.name[31:0]);
      for (int i = 0; i < total; i++) begin
        chk("payload", mem[base + 3 + i], v.seed + i);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    int k;
    // id rows cols name gap extra seed exp_err exp_sv
    vecs[0] = '{3'd0, 8'd8,   8'd10,  "CONV_RES", 1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'h01};
    vecs[1] = '{3'd3, 8'd3,   8'd3,   "MUL3X3__", 1'b1, 1'b0, 32'h0000_0100, 1'b0, 8'h09};
    vecs[2] = '{3'd5, 8'd0,   8'd4,   "ZERO_ROW", 1'b0, 1'b0, 32'h0000_0000, 1'b1, 8'h09};
    vecs[3] = '{3'd2, 8'd2,   8'd2,   "ADD2X2ab", 1'b0, 1'b0, 32'h0000_0200, 1'b0, 8'h0D};
    vecs[4] = '{3'd2, 8'd255, 8'd255, "TOO_BIG!", 1'b0, 1'b0, 32'h0000_0000, 1'b1, 8'h0D};
    vecs[5] = '{3'd4, 8'd2,   8'd2,   "EXTRA_BT", 1'b0, 1'b1, 32'h0000_0300, 1'b0, 8'h1D};
    vecs[6] = '{3'd6, 8'd1,   8'd253, "FULLSLOT", 1'b0, 1'b0, 32'h0000_0400, 1'b0, 8'h5D};
    vecs[7] = '{3'd7, 8'd2,   8'd127, "OVER_ONE", 1'b0, 1'b0, 32'h0000_0000, 1'b1, 8'h5D};

    rst_n         = 1'b0;
    write_request = 1'b0;
    matrix_id     = '0;
    actual_rows   = '0;
    actual_cols   = '0;
    matrix_name   = '0;
    data_in       = '0;
    data_valid    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_write_ready", {31'd0, write_ready}, 32'd1);
    chk("rst_writer_ready", {31'd0, writer_ready}, 32'd0);
    chk("rst_write_done", {31'd0, write_done}, 32'd0);
    chk("rst_bram_we", {31'd0, bram_we}, 32'd0);
    chk("rst_slot_valid", {24'd0, slot_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset in the middle of the payload phase of slot 1.
    write_request = 1'b1;
    matrix_id     = 3'd1;
    actual_rows   = 8'd4;
    actual_cols   = 8'd4;
    matrix_name   = "PARTIAL_";
    @(negedge clk);
    k = 0;
    while (!writer_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    write_request = 1'b0;
    chk("mid_writer_ready", {31'd0, writer_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1;
      data_in    = 32'h7700 + i;
      @(negedge clk);
    end
    data_valid = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("midrst_write_ready", {31'd0, write_ready}, 32'd1);
    chk("midrst_writer_ready", {31'd0, writer_ready}, 32'd0);
    chk("midrst_write_done", {31'd0, write_done}, 32'd0);
    chk("midrst_write_error", {31'd0, write_error}, 32'd0);
    chk("midrst_bram_we", {31'd0, bram_we}, 32'd0);
    chk("midrst_bram_addr", {21'd0, bram_addr}, 32'd0);
    chk("midrst_bram_din", bram_din, 32'd0);
    chk("midrst_slot_valid", {24'd0, slot_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rv = '{3'd1, 8'd1, 8'd1, "AFTERRST", 1'b0, 1'b0, 32'h0000_0055, 1'b0, 8'h02};
    run_txn(rv);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
